fp32_acc_stream: RTL and testbench
==================================

# fp32_acc_stream

Streaming IEEE-754 single-precision accumulator in the CNN datapath, directly downstream of the 32-bit float multiplier. It sums a packet of products, terminated by `in_last`, into one dot-product partial sum and presents the result on a valid/ready output. One multi-cycle add runs at a time, with a fixed four-cycle cadence per input element.

## Interface
- `CNT_W`, default 16: width of the element counter reported with each result.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset; asserting it forces the reset state immediately.
- `in_valid` input 1: product word valid.
- `in_ready` output 1: block can accept a word; high only in IDLE.
- `in_data` input 32: fp32 product from the multiplier.
- `in_last` input 1: qualifies `in_data` as the final element of the packet.
- `out_valid` output 1: accumulated result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output 32: accumulated fp32 sum.
- `out_cnt` output CNT_W: number of elements in the packet; saturates at all-ones.

## Operation
- **Reset values:** state IDLE, internal accumulator +0 (`0x00000000`), count 0, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_cnt`=0.
- **IDLE:**
  - On `in_valid & in_ready`, latch `in_data`, `in_last` and the accumulator, increment the count, then go to ALIGN.
- **ALIGN:**
  - Unpack both operands and restore hidden bits.
  - Subnormal operands are flushed to signed zero.
  - Shift the smaller-exponent mantissa right by the exponent difference. Keep 3 extra low bits; a shift of 27 or more gives 0.
- **ADD:**
  - Add magnitudes if the signs match; otherwise subtract the smaller from the larger.
  - The result sign is the sign of the larger magnitude.
- **NORM:**
  - Normalize with a leading-one detect (left or right shift, single cycle) and adjust the exponent.
  - Truncate the low bits (round toward zero).
  - Write the result to the accumulator.
  - If the latched `in_last` is set, go to OUT; otherwise go to IDLE.
- **OUT:**
  - `out_valid`=1 with `out_data`/`out_cnt` held stable.
  - On `out_ready`: clear the accumulator to +0, clear the count, go to IDLE.
- **Special cases, applied in NORM and overriding the arithmetic:**
  - Any NaN operand gives `0x7FC00000`.
  - +Inf + -Inf gives `0x7FC00000`.
  - A single Inf operand gives that Inf.
  - Exponent overflow gives ±Inf (`0x7F800000` / `0xFF800000`).
  - Exponent underflow gives +0.
  - Exact cancellation gives +0.
  - -0 + -0 gives `0x80000000`.
- **Count:** saturates at 2^CNT_W-1; the summation continues unaffected.

## Timing
- `in_ready` is a registered decode of the IDLE state.
- Accept at edge N: the accumulator is updated at edge N+3, and `in_ready` is high again during cycle N+3, so back-to-back acceptance occurs every 4 cycles.
- Last element accepted at edge N: `out_valid` is high from edge N+3. The handshake completes at the first edge with `out_ready`=1, and `in_ready` is high the following cycle.
- `in_valid`/`in_data` are ignored outside IDLE; the upstream stage holds the word until `in_ready`.
- `out_ready` is ignored when `out_valid`=0.
- Reset asserted mid-add or mid-OUT discards the partial sum and count; outputs return to their reset values immediately, and no result is emitted.

## Configuration
- `FP32_ACC_RELU_EN` defined: on entry to OUT, a result with sign bit 1 (including -0 and -Inf) is replaced by +0; NaN `0x7FC00000` passes unchanged.
- Not defined: `out_data` is the raw accumulated sum.

## Test plan
- `0x3F800000`, `0x40000000`, `0x40400000` (last), `out_ready`=1 → `out_data`=`0x40C00000`, `out_cnt`=3, `in_ready` cadence of 4 cycles.
- `0x3FC00000` then `0xBFC00000` (last) → `out_data`=`0x00000000`.
- `0x7F800000` then `0xFF800000` (last) → `0x7FC00000`; separately `0x7F7FFFFF` + `0x7F7FFFFF` → `0x7F800000`.
- Single `0xC0000000` with `in_last` → `0xC0000000` without the macro, `0x00000000` with `FP32_ACC_RELU_EN`; subnormal `0x00000001` alone → `0x00000000`.
- `out_ready` held 0 for 5 cycles in OUT → `out_valid`, `out_data`, `out_cnt` stable and `in_ready`=0; `in_valid` pulses are dropped.
- `rst` pulsed low during ADD of element 2 of a packet → reset values immediately; a fresh packet `0x3F800000` (last) → `0x3F800000`, `out_cnt`=1.

Source files
------------

// File: rtl/fp32_acc_stream_if.sv
// ---------------------------------------------------------------------------
// fp32_acc_stream_if
// Stream bundle between the fp32 multiplier, the accumulator and the
// consumer of dot-product partial sums.
//   in_valid / in_ready / in_data / in_last : product word stream (into block)
//   out_valid / out_ready / out_data / out_cnt : accumulated result (out of block)
// Modports:
//   master : the environment (drives the product stream, accepts results)
//   slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface fp32_acc_stream_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/fp32_acc_stream.sv
// ---------------------------------------------------------------------------
// fp32_acc_stream
// Streaming IEEE-754 single-precision accumulator. Sums a packet of fp32
// products (terminated by in_last) into one partial sum with a fixed
// four-cycle cadence per element: IDLE -> ALIGN -> ADD -> NORM.
// Rounding is toward zero; subnormal inputs are flushed to signed zero.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fp32_acc_stream_if.slave (in_* product stream, out_* result)
//
// Build option:
//   FP32_ACC_RELU_EN : when defined, negative results (sign bit set, incl.
//                      -0 and -Inf) are presented as +0 on out_data.
// ---------------------------------------------------------------------------
module fp32_acc_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    fp32_acc_stream_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam logic [31:0]      QNAN_W  = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic fp_is_nan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] == 23'd0);
    endfunction

    // Result as presented to the consumer (accumulator always keeps raw sum).
    function automatic logic [31:0] out_filter(input logic [31:0] w);
`ifdef FP32_ACC_RELU_EN
        return w[31] ? 32'h0000_0000 : w;
`else
        return w;
`endif
    endfunction

    state_t           state_r;
    logic [31:0]      acc_r;
    logic [31:0]      op_r;
    logic             last_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [31:0]      out_data_r;
    logic [CNT_W-1:0] out_cnt_r;

    // ALIGN stage results (held stable through ADD and NORM)
    logic             big_sign_r;
    logic [7:0]       big_exp_r;
    logic [26:0]      big_man_r;
    logic [26:0]      small_man_r;
    logic             eff_sub_r;
    logic             spec_hit_r;
    logic [31:0]      spec_word_r;

    // ADD stage result: one carry bit above the 27-bit aligned mantissas
    logic [27:0]      sum_r;

    logic             a_zero_s;
    logic             b_zero_s;
    logic [30:0]      a_mag_s;
    logic [30:0]      b_mag_s;
    logic [31:0]      big_w_s;
    logic [31:0]      small_w_s;
    logic [26:0]      big_man_s;
    logic [26:0]      small_man_s;
    logic [7:0]       diff_s;
    logic [26:0]      small_sh_s;
    logic             spec_hit_s;
    logic [31:0]      spec_word_s;

    logic [4:0]       lead_s;
    logic [27:0]      norm_s;
    logic signed [9:0] exp_s;
    logic [31:0]      result_s;
    logic             unused_bits_s;

    // Operand unpack, magnitude ordering, alignment shift and special-value decode
    always_comb begin
        a_zero_s  = (acc_r[30:23] == 8'd0);
        b_zero_s  = (op_r[30:23] == 8'd0);
        // subnormals collapse to a signed zero before any comparison
        a_mag_s   = a_zero_s ? 31'd0 : acc_r[30:0];
        b_mag_s   = b_zero_s ? 31'd0 : op_r[30:0];
        if (a_mag_s >= b_mag_s) begin
            big_w_s   = {acc_r[31], a_mag_s};
            small_w_s = {op_r[31], b_mag_s};
        end else begin
            big_w_s   = {op_r[31], b_mag_s};
            small_w_s = {acc_r[31], a_mag_s};
        end
        big_man_s   = (big_w_s[30:23] == 8'd0) ? 27'd0 : {1'b1, big_w_s[22:0], 3'b000};
        small_man_s = (small_w_s[30:23] == 8'd0) ? 27'd0 : {1'b1, small_w_s[22:0], 3'b000};
        diff_s      = big_w_s[30:23] - small_w_s[30:23];
        small_sh_s  = (diff_s >= 8'd27) ? 27'd0 : (small_man_s >> diff_s);

        if (fp_is_nan(acc_r) || fp_is_nan(op_r)) begin
            spec_hit_s  = 1'b1;
            spec_word_s = QNAN_W;
        end else if (fp_is_inf(acc_r) && fp_is_inf(op_r) && (acc_r[31] != op_r[31])) begin
            spec_hit_s  = 1'b1;
            spec_word_s = QNAN_W;
        end else if (fp_is_inf(acc_r)) begin
            spec_hit_s  = 1'b1;
            spec_word_s = acc_r;
        end else if (fp_is_inf(op_r)) begin
            spec_hit_s  = 1'b1;
            spec_word_s = op_r;
        end else begin
            spec_hit_s  = 1'b0;
            spec_word_s = 32'h0000_0000;
        end
    end

    // Leading-one detect, normalize, truncate and apply special-case overrides
    always_comb begin
        lead_s = 5'd0;
        for (int i = 0; i < 28; i++) begin
            lead_s = sum_r[i] ? 5'(i) : lead_s;
        end
        // move the leading one to bit 27; fraction is the next 23 bits
        norm_s = sum_r << (5'd27 - lead_s);
        // hidden-bit position of an unshifted result is bit 26
        exp_s  = $signed({2'b00, big_exp_r}) + $signed({5'b00000, lead_s}) - 10'sd26;

        if (spec_hit_r) begin
            result_s = spec_word_r;
        end else if (sum_r == 28'd0) begin
            // only two like-signed zeros keep a sign; cancellation is +0
            result_s = {(~eff_sub_r) & big_sign_r, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            result_s = {big_sign_r, 8'hFF, 23'd0};
        end else if (exp_s <= 10'sd0) begin
            result_s = 32'h0000_0000;
        end else begin
            result_s = {big_sign_r, exp_s[7:0], norm_s[26:4]};
        end
        unused_bits_s = ^{norm_s[27], norm_s[3:0]};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= 32'h0000_0000;
            op_r        <= 32'h0000_0000;
            last_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_cnt_r   <= {CNT_W{1'b0}};
            big_sign_r  <= 1'b0;
            big_exp_r   <= 8'd0;
            big_man_r   <= 27'd0;
            small_man_r <= 27'd0;
            eff_sub_r   <= 1'b0;
            spec_hit_r  <= 1'b0;
            spec_word_r <= 32'h0000_0000;
            sum_r       <= 28'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        op_r       <= bus.in_data;
                        last_r     <= bus.in_last;
                        cnt_r      <= (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
                        in_ready_r <= 1'b0;
                        state_r    <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    big_sign_r  <= big_w_s[31];
                    big_exp_r   <= big_w_s[30:23];
                    big_man_r   <= big_man_s;
                    small_man_r <= small_sh_s;
                    eff_sub_r   <= big_w_s[31] ^ small_w_s[31];
                    spec_hit_r  <= spec_hit_s;
                    spec_word_r <= spec_word_s;
                    state_r     <= ST_ADD;
                end
                ST_ADD: begin
                    if (eff_sub_r) begin
                        sum_r <= {1'b0, big_man_r} - {1'b0, small_man_r};
                    end else begin
                        sum_r <= {1'b0, big_man_r} + {1'b0, small_man_r};
                    end
                    state_r <= ST_NORM;
                end
                ST_NORM: begin
                    acc_r <= result_s;
                    if (last_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= out_filter(result_s);
                        out_cnt_r   <= cnt_r;
                        state_r     <= ST_OUT;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        acc_r       <= 32'h0000_0000;
                        cnt_r       <= {CNT_W{1'b0}};
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_fp32_acc_stream.sv
// ---------------------------------------------------------------------------
// tb_fp32_acc_stream
// Scoreboard bench for fp32_acc_stream. Stimulus pushes the expected result
// of each packet into a queue; a monitor pops and compares on every output
// handshake. A narrow counter (CNT_W=3) lets random packets reach the
// saturation point of out_cnt.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp32_acc_stream;

    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    fp32_acc_stream_if #(.CNT_W(CNT_W)) bus ();

    fp32_acc_stream #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total;
    int          bad;
    logic [31:0] exp_data_q[$];
    int          exp_cnt_q[$];
    logic [31:0] m_acc;
    int          m_cnt;
    bit          dir_en;
    logic [31:0] dir_data;
    int          rdy_mode;
    longint      acc_t;

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // Reference fp32 add from the arithmetic rules: integer mantissas,
    // truncating alignment with 3 extra bits, loop normalization.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, hi, lo;
        longint mh, ml, v, mag;
        int e, d;
        logic sgn;
        bit nan_x, nan_y, inf_x, inf_y;
        nan_x = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        nan_y = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        inf_x = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        inf_y = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        if (nan_x || nan_y) return 32'h7FC00000;
        if (inf_x && inf_y && (x[31] != y[31])) return 32'h7FC00000;
        if (inf_x) return x;
        if (inf_y) return y;
        a = (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
        b = (y[30:23] == 8'd0) ? {y[31], 31'd0} : y;
        if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
        else begin hi = b; lo = a; end
        mh = (hi[30:23] == 8'd0) ? 64'sd0 : longint'({1'b1, hi[22:0]}) * 64'sd8;
        ml = (lo[30:23] == 8'd0) ? 64'sd0 : longint'({1'b1, lo[22:0]}) * 64'sd8;
        d  = int'(hi[30:23]) - int'(lo[30:23]);
        if (d >= 27) ml = 64'sd0;
        else ml = ml >>> d;
        v = (hi[31] ? -mh : mh) + (lo[31] ? -ml : ml);
        if (v == 64'sd0) return (a[31] && b[31]) ? 32'h80000000 : 32'h00000000;
        sgn = (v < 64'sd0);
        mag = sgn ? -v : v;
        e   = int'(hi[30:23]);
        while (mag >= 64'sd134217728) begin mag = mag >>> 1; e++; end
        while (mag < 64'sd67108864) begin mag = mag <<< 1; e--; end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        if (e <= 0) return 32'h00000000;
        return {sgn, e[7:0], mag[25:3]};
    endfunction

    function automatic logic [31:0] ref_out(input logic [31:0] w);
`ifdef FP32_ACC_RELU_EN
        return w[31] ? 32'h00000000 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        int r;
        logic s;
        r = int'($urandom_range(0, 99));
        s = 1'($urandom_range(0, 1));
        if (r < 78) return {s, 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
        if (r < 83) return {s, 31'd0};
        if (r < 87) return {s, 8'd0, 23'($urandom_range(1, 8388607))};
        if (r < 90) return {s, 8'hFF, 23'd0};
        if (r < 92) return {1'b0, 8'hFF, 23'($urandom_range(1, 8388607))};
        return {s, 8'(250 + $urandom_range(0, 4)), 23'($urandom)};
    endfunction

    // out_ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // monitor: compare on each output handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_data_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%08h required=none", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_data_q.pop_front());
                    check("out_cnt", 32'(bus.out_cnt), 32'(exp_cnt_q.pop_front()));
                end
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic last);
        int n;
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_last  = last;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            @(posedge clk);
            acc_t = $time;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
            return;
        end
        m_acc = ref_add(m_acc, w);
        m_cnt = (m_cnt == CMAX) ? m_cnt : m_cnt + 1;
        if (last) begin
            exp_data_q.push_back(dir_en ? dir_data : ref_out(m_acc));
            exp_cnt_q.push_back(m_cnt);
            m_acc = 32'h0;
            m_cnt = 0;
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_data_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_data_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout actual=pending%0d required=pending0", exp_data_q.size());
            exp_data_q.delete();
            exp_cnt_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint t0, t1, t2;
        total = 0;
        bad = 0;
        m_acc = 32'h0;
        m_cnt = 0;
        dir_en = 1'b0;
        dir_data = 32'h0;
        rdy_mode = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        bus.in_last = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1 + 2 + 3 = 6, with four-cycle acceptance cadence
        dir_en = 1'b1;
        dir_data = 32'h40C00000;
        send(32'h3F800000, 1'b0); t0 = acc_t;
        send(32'h40000000, 1'b0); t1 = acc_t;
        send(32'h40400000, 1'b1); t2 = acc_t;
        check("cadence_1", 32'((t1 - t0) / 10), 32'd4);
        check("cadence_2", 32'((t2 - t1) / 10), 32'd4);
        wait_empty();

        // exact cancellation
        dir_data = 32'h00000000;
        send(32'h3FC00000, 1'b0);
        send(32'hBFC00000, 1'b1);
        wait_empty();

        // +Inf + -Inf, then exponent overflow
        dir_data = 32'h7FC00000;
        send(32'h7F800000, 1'b0);
        send(32'hFF800000, 1'b1);
        wait_empty();
        dir_data = 32'h7F800000;
        send(32'h7F7FFFFF, 1'b0);
        send(32'h7F7FFFFF, 1'b1);
        wait_empty();

        // negative single element, subnormal flush
`ifdef FP32_ACC_RELU_EN
        dir_data = 32'h00000000;
`else
        dir_data = 32'hC0000000;
`endif
        send(32'hC0000000, 1'b1);
        wait_empty();
        dir_data = 32'h00000000;
        send(32'h00000001, 1'b1);
        wait_empty();

        // output held under back-pressure; input pulses dropped
        rdy_mode = 2;
        dir_data = 32'h40000000;
        @(posedge clk);
        #1;
        send(32'h40000000, 1'b1);
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_data", bus.out_data, 32'h40000000);
            check("hold_out_cnt", 32'(bus.out_cnt), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            bus.in_valid = (k % 2 == 0);
            bus.in_data = 32'h3F800000;
            bus.in_last = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        wait_empty();

        // reset during ADD of element 2
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", bus.out_data, 32'h0);
        check("mid_rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        m_acc = 32'h0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        dir_data = 32'h3F800000;
        send(32'h3F800000, 1'b1);
        wait_empty();

        // random packets against the reference model
        dir_en = 1'b0;
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(1, 10));
            for (int j = 0; j < len; j++) begin
                send(rand_word(), (j == len - 1));
            end
        end
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
